gray_pattern_sched: RTL and testbench
=====================================

GRAY_PATTERN_SCHED -- requirements
Module: gray_pattern_sched

Interface
REQ-001 Parameter GRAY_RESOLUTION, default 1920: number of gray-LUT entries; legal coords are 0..GRAY_RESOLUTION-1.
REQ-002 Parameter H_ACTIVE, default 1920: active pixels per line.
REQ-003 Parameter DWELL_FRAMES, default 120: frames per pattern in auto mode; minimum 1.
REQ-004 Parameter FLAT_STEP, default 128: coord increment per frame in the FLAT pattern.
REQ-005 clk  in  1  sole clock; all logic is on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 frame_start  in  1  one-cycle pulse at the start of each frame, during blanking.
REQ-008 line_start  in  1  one-cycle pulse before each line's active region.
REQ-009 de  in  1  active-video enable, contiguous H_ACTIVE cycles per line.
REQ-010 auto_en  in  1  1 = advance pattern every DWELL_FRAMES frames.
REQ-011 next_req  in  1  one-cycle manual "next pattern" pulse, already debounced.
REQ-012 lut_coord  out  23  gray-LUT address.
REQ-013 lut_valid  out  1  lut_coord is meaningful this cycle.
REQ-014 pix_valid  out  1  lut_valid delayed 1 cycle, aligned with the LUT's registered gray_data.
REQ-015 pattern_id  out  2  active pattern: 0 RAMP_H, 1 RAMP_H_INV, 2 FLAT.

Function
REQ-016 FSM states: IDLE and RUN; IDLE goes to RUN on the first frame_start; RUN never returns to IDLE except through reset.
REQ-017 In IDLE, lut_valid and pix_valid shall be 0 regardless of de.
REQ-018 x counter: cleared on line_start; increments on each de cycle; saturates at H_ACTIVE-1.
REQ-019 lut_coord, registered (1-cycle latency from de):
- RAMP_H: x*(GRAY_RESOLUTION-1)/(H_ACTIVE-1); when H_ACTIVE equals GRAY_RESOLUTION this reduces to x.
- RAMP_H_INV: (GRAY_RESOLUTION-1) minus the RAMP_H value.
- FLAT: the frame level register.
REQ-020 lut_valid shall equal de registered by one cycle while in RUN.
REQ-021 lut_coord shall hold its last value when lut_valid is 0.
REQ-022 The FLAT level shall reset to 0 and, on each frame_start while pattern_id is 2, add FLAT_STEP; if the sum exceeds GRAY_RESOLUTION-1 it wraps to 0.
REQ-023 Dwell counter: counts frame_start pulses while auto_en is 1; when it reaches DWELL_FRAMES it sets advance-pending and clears.
REQ-024 The dwell counter shall clear when auto_en is 0.
REQ-025 A next_req pulse shall set advance-pending and clear the dwell counter.
REQ-026 Pattern changes shall take effect only on frame_start, never mid-frame.
REQ-027 On frame_start with advance-pending set, pattern_id shall advance 0 to 1 to 2 and wrap to 0, then pending clears.
REQ-028 Multiple next_req pulses and/or a dwell expiry within one frame shall advance the pattern exactly once.
REQ-029 A next_req arriving in the same cycle as frame_start shall be applied at the following frame_start.
REQ-030 On entering FLAT the level shall restart at 0; at that first frame_start the level is 0, not FLAT_STEP.
REQ-031 If frame_start and line_start coincide, both shall be processed: the pattern update and the x-counter clear.

Reset
REQ-032 While rst is high: FSM = IDLE; pattern_id = 0; x counter, dwell counter, FLAT level, lut_coord = 0; lut_valid, pix_valid, advance-pending = 0.
REQ-033 A reset asserted mid-frame shall take effect asynchronously.
REQ-034 After a mid-frame reset the block shall output nothing valid until the next frame_start.

Structure
REQ-035 Pattern encodings (PAT_RAMP_H, PAT_RAMP_H_INV, PAT_FLAT) and the NUM_PATTERNS constant shall live in a shared package, gray_pattern_pkg.
REQ-036 The dwell/advance logic shall be one sub-module, pattern_dwell_timer (inputs frame_start, auto_en, next_req; output advance pulse); all other logic stays in the top.

Verification
REQ-037 RAMP_H, defaults, one line of 1920 de cycles -> lut_coord 0..1919 in order, 1 cycle after de; pix_valid 2 cycles after de; last coord 1919.
REQ-038 next_req mid-frame on pattern 0 -> pattern_id stays 0 until next frame_start, then 1; next line's first lut_coord = 1919, last = 0.
REQ-039 FLAT pattern over 16 frames -> level sequence 0,128,...,1792, then 0 (1920 > 1919 wraps).
REQ-040 auto_en=1, DWELL_FRAMES=3 -> pattern_id advances every 3rd frame_start, sequence 0,1,2,0; next_req plus expiry in the same frame -> exactly one advance.
REQ-041 rst pulsed mid-line while de=1 -> lut_valid and pix_valid drop immediately, pattern_id = 0, no valid output until after the next frame_start.
REQ-042 de held for 2000 cycles -> lut_coord saturates at 1919 and never exceeds GRAY_RESOLUTION-1.

Source files
------------

// File: rtl/gray_pattern_pkg.sv
// rtl/gray_pattern_pkg.sv - shared pattern encodings, FSM states and sizing for the gray pattern scheduler
package gray_pattern_pkg;

   localparam int NUM_PATTERNS = 3;
   localparam int COORD_W      = 23;

   typedef enum logic [1:0] {
      PAT_RAMP_H     = 2'd0,
      PAT_RAMP_H_INV = 2'd1,
      PAT_FLAT       = 2'd2
   } pattern_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic pattern_t next_pattern(input pattern_t p);
      pattern_t n;
      if (int'(p) >= NUM_PATTERNS - 1)
         n = PAT_RAMP_H;
      else
         n = pattern_t'(p + 2'd1);
      return n;
   endfunction

endpackage

// File: rtl/pattern_dwell_timer.sv
// rtl/pattern_dwell_timer.sv - dwell counter and advance-pending latch; emits an advance pulse on frame_start
module pattern_dwell_timer #(
   parameter int DWELL_FRAMES = 120
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   input  logic auto_en,
   input  logic next_req,
   output logic advance
);

   localparam int               CNT_W    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_FRAMES - 1);

   logic [CNT_W-1:0] cnt;
   logic             pending;
   logic             expire;

   // An expiry on this frame_start is folded into the same advance, so requests merge into one step.
   assign expire  = frame_start && auto_en && (cnt == CNT_LAST);
   assign advance = frame_start && (pending || expire);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         if (!auto_en || next_req || expire)
            cnt <= '0;
         else if (frame_start)
            cnt <= cnt + 1'b1;

         // A request coinciding with frame_start survives the clear and lands on the following frame.
         if (next_req)
            pending <= 1'b1;
         else if (frame_start)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/gray_pattern_sched.sv
// rtl/gray_pattern_sched.sv - gray test-pattern scheduler producing per-pixel gray-LUT coordinates
module gray_pattern_sched
   import gray_pattern_pkg::*;
#(
   parameter int GRAY_RESOLUTION = 1920,
   parameter int H_ACTIVE        = 1920,
   parameter int DWELL_FRAMES    = 120,
   parameter int FLAT_STEP       = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic        de,
   input  logic        auto_en,
   input  logic        next_req,
   output logic [22:0] lut_coord,
   output logic        lut_valid,
   output logic        pix_valid,
   output logic [1:0]  pattern_id
);

   localparam int                 X_W       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [X_W-1:0]     X_LAST    = X_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRAY_RESOLUTION - 1);
   localparam logic [COORD_W:0]   STEP      = (COORD_W + 1)'(FLAT_STEP);

   state_t               state, state_nx;
   pattern_t             pattern;
   logic [X_W-1:0]       x;
   logic [COORD_W-1:0]   flat_lvl;
   logic [COORD_W:0]     flat_sum;
   logic [COORD_W-1:0]   ramp;
   logic [COORD_W-1:0]   coord_nx;
   logic                 advance;
   logic                 running;

   pattern_dwell_timer #(
      .DWELL_FRAMES(DWELL_FRAMES)
   ) u_dwell (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .auto_en    (auto_en),
      .next_req   (next_req),
      .advance    (advance)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == ST_IDLE && frame_start)
         state_nx = ST_RUN;
   end

   assign running  = (state == ST_RUN);
   assign flat_sum = {1'b0, flat_lvl} + STEP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern  <= PAT_RAMP_H;
         flat_lvl <= '0;
      end else if (frame_start) begin
         if (advance) begin
            pattern  <= next_pattern(pattern);
            flat_lvl <= '0;
         end else if (pattern == PAT_FLAT) begin
            flat_lvl <= (flat_sum > {1'b0, COORD_MAX}) ? '0 : flat_sum[COORD_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         x <= '0;
      else if (line_start)
         x <= '0;
      else if (de && x != X_LAST)
         x <= x + 1'b1;
   end

   // The scaling divider only exists when the LUT and the line differ in size.
   generate
      if (GRAY_RESOLUTION == H_ACTIVE) begin : g_ramp_direct
         assign ramp = COORD_W'(x);
      end else begin : g_ramp_scaled
         assign ramp = COORD_W'((48'(x) * 48'(GRAY_RESOLUTION - 1)) / 48'(H_ACTIVE - 1));
      end
   endgenerate

   always_comb begin
      coord_nx = flat_lvl;
      case (pattern)
         PAT_RAMP_H:     coord_nx = ramp;
         PAT_RAMP_H_INV: coord_nx = COORD_MAX - ramp;
         default:        coord_nx = flat_lvl;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_coord <= '0;
         lut_valid <= 1'b0;
         pix_valid <= 1'b0;
      end else begin
         lut_valid <= running && de;
         pix_valid <= lut_valid;
         if (running && de)
            lut_coord <= coord_nx;
      end
   end

   assign pattern_id = pattern;

endmodule

// File: tb/tb_gray_pattern_sched.sv
// tb/tb_gray_pattern_sched.sv - directed self-checking bench for gray_pattern_sched
module tb_gray_pattern_sched;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic        line_start;
   logic        de;
   logic        auto_en;
   logic        next_req;
   logic [22:0] lut_coord;
   logic        lut_valid;
   logic        pix_valid;
   logic [1:0]  pattern_id;

   int n_checks = 0;
   int n_fail   = 0;

   gray_pattern_sched #(
      .GRAY_RESOLUTION(1920),
      .H_ACTIVE       (1920),
      .DWELL_FRAMES   (3),
      .FLAT_STEP      (128)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .line_start (line_start),
      .de         (de),
      .auto_en    (auto_en),
      .next_req   (next_req),
      .lut_coord  (lut_coord),
      .lut_valid  (lut_valid),
      .pix_valid  (pix_valid),
      .pattern_id (pattern_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int exp_coord(input int pat, input int i, input int lvl);
      int x;
      x = (i > 1919) ? 1919 : i;
      case (pat)
         0:       return x;
         1:       return 1919 - x;
         default: return lvl;
      endcase
   endfunction

   task automatic pulse(input bit fs, input bit ls, input bit nr);
      frame_start = fs;
      line_start  = ls;
      next_req    = nr;
      @(negedge clk);
      frame_start = 1'b0;
      line_start  = 1'b0;
      next_req    = 1'b0;
   endtask

   task automatic frame();
      pulse(1'b1, 1'b0, 1'b0);
   endtask

   // Drives one line of n de cycles and tallies every per-cycle deviation.
   task automatic run_line(input int n, input bit do_ls, input bit exp_run, input int pat, input int lvl,
                           output int errs, output int first, output int last);
      int e;
      int held;
      errs  = 0;
      first = -1;
      last  = -1;
      held  = -1;
      if (do_ls) begin
         pulse(1'b0, 1'b1, 1'b0);
         @(negedge clk);
      end
      for (int i = 0; i <= n + 1; i++) begin
         de = (i < n);
         @(negedge clk);
         if (exp_run) begin
            if (lut_valid !== (i < n)) errs++;
            if (pix_valid !== (i >= 1 && i <= n)) errs++;
            if (i < n) begin
               e = exp_coord(pat, i, lvl);
               if (int'(lut_coord) != e) errs++;
               if (int'(lut_coord) > 1919) errs++;
               if (i == 0) first = int'(lut_coord);
               last = int'(lut_coord);
               held = e;
            end else if (int'(lut_coord) != held) begin
               errs++;
            end
         end else if (lut_valid !== 1'b0 || pix_valid !== 1'b0) begin
            errs++;
         end
      end
      de = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int errs, first, last, lvl;
      int exp_auto[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 0};
      rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; de = 1'b0; auto_en = 1'b0; next_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_lut_valid", lut_valid, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pattern", pattern_id, 0);
      check("rst_coord", lut_coord, 0);
      rst = 1'b0;
      @(negedge clk);

      run_line(10, 1'b1, 1'b0, 0, 0, errs, first, last);
      check("idle_no_valid", errs, 0);

      frame();
      run_line(1920, 1'b1, 1'b1, 0, 0, errs, first, last);
      check("ramp_errs", errs, 0);
      check("ramp_first", first, 0);
      check("ramp_last", last, 1919);

      pulse(1'b0, 1'b0, 1'b1);
      run_line(8, 1'b1, 1'b1, 0, 0, errs, first, last);
      check("midframe_hold_errs", errs, 0);
      check("midframe_pattern", pattern_id, 0);
      frame();
      check("next_pattern", pattern_id, 1);
      run_line(1920, 1'b1, 1'b1, 1, 0, errs, first, last);
      check("inv_errs", errs, 0);
      check("inv_first", first, 1919);
      check("inv_last", last, 0);

      pulse(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      pulse(1'b0, 1'b0, 1'b1);
      frame();
      check("multi_req_once", pattern_id, 2);
      for (int f = 0; f < 16; f++) begin
         if (f > 0) frame();
         lvl = (f == 15) ? 0 : f * 128;
         run_line(4, 1'b1, 1'b1, 2, lvl, errs, first, last);
         check($sformatf("flat_lvl_f%0d", f), first, lvl);
         check($sformatf("flat_errs_f%0d", f), errs, 0);
      end
      check("flat_pattern", pattern_id, 2);

      pulse(1'b1, 1'b0, 1'b1);
      check("coinc_req_deferred", pattern_id, 2);
      @(negedge clk);
      frame();
      check("coinc_req_applied", pattern_id, 0);

      auto_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         frame();
         check($sformatf("auto_fs%0d", k + 1), pattern_id, exp_auto[k]);
      end
      @(negedge clk); frame();
      @(negedge clk); frame();
      check("auto_fs11", pattern_id, 0);
      pulse(1'b0, 1'b0, 1'b1);
      frame();
      check("req_plus_dwell_once", pattern_id, 1);
      @(negedge clk); frame();
      check("dwell_restart_fs13", pattern_id, 1);
      @(negedge clk); frame();
      check("dwell_restart_fs14", pattern_id, 2);
      auto_en = 1'b0;

      de = 1'b1;
      repeat (5) @(negedge clk);
      de = 1'b0;
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b1, 1'b0);
      check("fs_ls_pattern", pattern_id, 0);
      run_line(10, 1'b0, 1'b1, 0, 0, errs, first, last);
      check("fs_ls_errs", errs, 0);
      check("fs_ls_first", first, 0);
      check("fs_ls_last", last, 9);

      run_line(2000, 1'b1, 1'b1, 0, 0, errs, first, last);
      check("sat_errs", errs, 0);
      check("sat_last", last, 1919);

      pulse(1'b0, 1'b0, 1'b1);
      frame();
      check("pre_rst_pattern", pattern_id, 1);
      pulse(1'b0, 1'b1, 1'b0);
      de = 1'b1;
      repeat (10) @(negedge clk);
      check("pre_rst_valid", lut_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_lut_valid", lut_valid, 0);
      check("async_rst_pix_valid", pix_valid, 0);
      check("async_rst_pattern", pattern_id, 0);
      check("async_rst_coord", lut_coord, 0);
      @(negedge clk);
      rst = 1'b0;
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (lut_valid !== 1'b0 || pix_valid !== 1'b0) errs++;
      end
      de = 1'b0;
      check("post_rst_quiet", errs, 0);
      frame();
      run_line(16, 1'b1, 1'b1, 0, 0, errs, first, last);
      check("post_rst_errs", errs, 0);
      check("post_rst_last", last, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
